rom_dl_packer: RTL and testbench

- Sits between the HPS ioctl download port and the SDRAM wishbone slave, on the RISC OS ROM download path.
- Packs 16-bit ioctl halfwords into 32-bit wishbone write cycles.
- Back-pressures the HPS with ioctl_wait while a write is pending.
- Flushes a dangling halfword when the download ends, then signals completion so the top level can release reset.

---
 rtl/rom_dl_pkg.sv | 20 ++
 rtl/rom_dl_wb_master.sv | 64 ++++++
 rtl/rom_dl_packer.sv | 228 ++++++++++++++++++++++
 tb/tb_rom_dl_packer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download packer: FSM states, byte-lane selects, lane mask helper.
package rom_dl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
      FLUSH,
      DONE
   } state_t;

   localparam logic [3:0] SEL_LO  = 4'b0011;
   localparam logic [3:0] SEL_HI  = 4'b1100;
   localparam logic [3:0] SEL_ALL = 4'b1111;

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/rom_dl_wb_master.sv
// Single-beat wishbone write engine: load latches a write, held stable until wb_ack.
// Bus signals are registered; load is ignored while a cycle is in flight.
module rom_dl_wb_master (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        load,
   input  logic [3:0]  load_sel,
   input  logic [25:0] load_adr,
   input  logic [31:0] load_dat,
   output logic        busy,
   output logic        acked,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [3:0]  wb_sel,
   output logic [25:0] wb_adr,
   output logic [31:0] wb_dat_o,
   input  logic        wb_ack
);
   logic        cyc_q, cyc_d;
   logic [3:0]  sel_q, sel_d;
   logic [25:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;

   always_comb begin
      cyc_d = cyc_q;
      sel_d = sel_q;
      adr_d = adr_q;
      dat_d = dat_q;
      if (cyc_q && wb_ack) begin
         cyc_d = 1'b0;
      end else if (load && !cyc_q) begin
         cyc_d = 1'b1;
         sel_d = load_sel;
         adr_d = load_adr;
         dat_d = load_dat;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cyc_q <= 1'b0;
         sel_q <= '0;
         adr_q <= '0;
         dat_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         sel_q <= sel_d;
         adr_q <= adr_d;
         dat_q <= dat_d;
      end
   end

   // An ack outside a cycle (e.g. late after reset) is not ours.
   assign acked    = cyc_q & wb_ack;
   assign busy     = cyc_q;
   assign wb_cyc   = cyc_q;
   assign wb_stb   = cyc_q;
   assign wb_we    = cyc_q;
   assign wb_sel   = sel_q;
   assign wb_adr   = adr_q;
   assign wb_dat_o = dat_q;

endmodule

// File: rtl/rom_dl_packer.sv
// Packs 16-bit ioctl ROM download halfwords into 32-bit wishbone writes; ROM_DL_CHECKSUM_EN adds a checksum output.
// Bus cycle starts one edge after ioctl_wr; ioctl_wait holds the HPS until the cycle after the last ack.
module rom_dl_packer
   import rom_dl_pkg::*;
#(
   parameter logic [25:0] BASE_ADDR    = 26'h400000,
   parameter logic [31:0] REGION_BYTES = 32'h400000,
   parameter int          ADDR_W       = 25
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              dl_active,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [15:0]       ioctl_dout,
   output logic              ioctl_wait,
   output logic              wb_cyc,
   output logic              wb_stb,
   output logic              wb_we,
   output logic [3:0]        wb_sel,
   output logic [25:0]       wb_adr,
   output logic [31:0]       wb_dat_o,
   input  logic              wb_ack,
   output logic              done,
   output logic              overflow,
   output logic [21:0]       words_written
`ifdef ROM_DL_CHECKSUM_EN
   ,
   output logic [31:0]       checksum
`endif
);
   localparam int WW = ADDR_W - 2;

   state_t          state_q, state_d;
   logic            dl_q, dl_d;
   logic            buf_vld_q, buf_vld_d;
   logic [WW-1:0]   buf_w_q, buf_w_d;
   logic [15:0]     buf_dat_q, buf_dat_d;
   logic            pend_vld_q, pend_vld_d;
   logic [WW-1:0]   pend_w_q, pend_w_d;
   logic [15:0]     pend_dat_q, pend_dat_d;
   logic            wait_q, wait_d;
   logic            overflow_q, overflow_d;
   logic [21:0]     words_q, words_d;

   logic            load, busy, acked, rising;
   logic [3:0]      load_sel;
   logic [WW-1:0]   load_w;
   logic [31:0]     load_dat;
   logic [25:0]     load_adr;
   logic [WW-1:0]   wr_w;
   logic            wr_hi, wr_in_range, addr_lsb_unused;

   assign wr_w            = ioctl_addr[ADDR_W-1:2];
   assign wr_hi           = ioctl_addr[1];
   assign addr_lsb_unused = ioctl_addr[0];
   assign wr_in_range     = 32'({wr_w, 2'b00}) < REGION_BYTES;
   assign rising          = dl_active && !dl_q;
   assign dl_d            = dl_active;
   assign load_adr        = BASE_ADDR + 26'({load_w, 2'b00});

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         dl_q       <= 1'b0;
         buf_vld_q  <= 1'b0;
         buf_w_q    <= '0;
         buf_dat_q  <= '0;
         pend_vld_q <= 1'b0;
         pend_w_q   <= '0;
         pend_dat_q <= '0;
         wait_q     <= 1'b0;
         overflow_q <= 1'b0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         dl_q       <= dl_d;
         buf_vld_q  <= buf_vld_d;
         buf_w_q    <= buf_w_d;
         buf_dat_q  <= buf_dat_d;
         pend_vld_q <= pend_vld_d;
         pend_w_q   <= pend_w_d;
         pend_dat_q <= pend_dat_d;
         wait_q     <= wait_d;
         overflow_q <= overflow_d;
         words_q    <= words_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      buf_vld_d  = buf_vld_q;
      buf_w_d    = buf_w_q;
      buf_dat_d  = buf_dat_q;
      pend_vld_d = pend_vld_q;
      pend_w_d   = pend_w_q;
      pend_dat_d = pend_dat_q;
      wait_d     = wait_q;
      overflow_d = overflow_q;
      words_d    = words_q + {21'd0, acked};
      load       = 1'b0;
      load_sel   = SEL_LO;
      load_w     = buf_w_q;
      load_dat   = {buf_dat_q, buf_dat_q};
      unique case (state_q)
         IDLE: begin
            if (rising) begin
               state_d    = COLLECT;
               buf_vld_d  = 1'b0;
               pend_vld_d = 1'b0;
               overflow_d = 1'b0;
               words_d    = '0;
            end
         end
         COLLECT: begin
            if (ioctl_wr && !wr_in_range) begin
               overflow_d = 1'b1;
            end else if (ioctl_wr) begin
               if (!wr_hi) begin
                  // A held half of another word goes out first; the new half takes its place.
                  load      = buf_vld_q && (buf_w_q != wr_w);
                  buf_vld_d = 1'b1;
                  buf_w_d   = wr_w;
                  buf_dat_d = ioctl_dout;
               end else if (buf_vld_q && (buf_w_q == wr_w)) begin
                  load      = 1'b1;
                  load_sel  = SEL_ALL;
                  load_w    = wr_w;
                  load_dat  = {ioctl_dout, buf_dat_q};
                  buf_vld_d = 1'b0;
               end else if (buf_vld_q) begin
                  load       = 1'b1;
                  buf_vld_d  = 1'b0;
                  pend_vld_d = 1'b1;
                  pend_w_d   = wr_w;
                  pend_dat_d = ioctl_dout;
               end else begin
                  load     = 1'b1;
                  load_sel = SEL_HI;
                  load_w   = wr_w;
                  load_dat = {ioctl_dout, ioctl_dout};
               end
            end
            if (load) begin
               state_d = WRITE;
               wait_d  = 1'b1;
            end else if (!dl_active) begin
               if (buf_vld_d) begin
                  load      = 1'b1;
                  load_w    = buf_w_d;
                  load_dat  = {buf_dat_d, buf_dat_d};
                  buf_vld_d = 1'b0;
                  state_d   = FLUSH;
               end else begin
                  state_d = DONE;
               end
            end
         end
         WRITE: begin
            if (ioctl_wr) overflow_d = 1'b1;
            if (acked) begin
               if (!pend_vld_q) begin
                  state_d = COLLECT;
                  wait_d  = 1'b0;
               end
            end else if (!busy && pend_vld_q) begin
               load       = 1'b1;
               load_sel   = SEL_HI;
               load_w     = pend_w_q;
               load_dat   = {pend_dat_q, pend_dat_q};
               pend_vld_d = 1'b0;
            end
         end
         FLUSH: begin
            if (acked) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      done          = (state_q == DONE);
      ioctl_wait    = wait_q;
      overflow      = overflow_q;
      words_written = words_q;
   end

   rom_dl_wb_master u_wb (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .load     (load),
      .load_sel (load_sel),
      .load_adr (load_adr),
      .load_dat (load_dat),
      .busy     (busy),
      .acked    (acked),
      .wb_cyc   (wb_cyc),
      .wb_stb   (wb_stb),
      .wb_we    (wb_we),
      .wb_sel   (wb_sel),
      .wb_adr   (wb_adr),
      .wb_dat_o (wb_dat_o),
      .wb_ack   (wb_ack)
   );

`ifdef ROM_DL_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == IDLE && rising) csum_d = '0;
      else if (acked) csum_d = csum_q + (wb_dat_o & lane_mask(wb_sel));
   end

   always_ff @(posedge clk_sys) begin
      if (reset) csum_q <= '0;
      else       csum_q <= csum_d;
   end

   assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_dl_packer.sv
// Directed bench for rom_dl_packer: vector table inside one download plus hand sequences for flush, late ack, overflow, reset.
module tb_rom_dl_packer;

   logic        clk_sys;
   logic        reset;
   logic        dl_active;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [15:0] ioctl_dout;
   logic        ioctl_wait;
   logic        wb_cyc, wb_stb, wb_we;
   logic [3:0]  wb_sel;
   logic [25:0] wb_adr;
   logic [31:0] wb_dat_o;
   logic        wb_ack;
   logic        done;
   logic        overflow;
   logic [21:0] words_written;
`ifdef ROM_DL_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   rom_dl_packer dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .dl_active     (dl_active),
      .ioctl_wr      (ioctl_wr),
      .ioctl_addr    (ioctl_addr),
      .ioctl_dout    (ioctl_dout),
      .ioctl_wait    (ioctl_wait),
      .wb_cyc        (wb_cyc),
      .wb_stb        (wb_stb),
      .wb_we         (wb_we),
      .wb_sel        (wb_sel),
      .wb_adr        (wb_adr),
      .wb_dat_o      (wb_dat_o),
      .wb_ack        (wb_ack),
      .done          (done),
      .overflow      (overflow),
      .words_written (words_written)
`ifdef ROM_DL_CHECKSUM_EN
      ,
      .checksum      (checksum)
`endif
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wishbone slave model: acks after ack_dly idle cycles, logs each write, checks stability.
   logic        slave_en;
   logic        force_ack;
   int          ack_dly;
   int          ack_cnt;
   int          stab_err;
   logic [25:0] log_adr[$];
   logic [31:0] log_dat[$];
   logic [3:0]  log_sel[$];
   logic [25:0] ref_adr;
   logic [31:0] ref_dat;
   logic [3:0]  ref_sel;

   initial begin
      wb_ack   = 1'b0;
      ack_cnt  = 0;
      stab_err = 0;
      forever begin
         @(negedge clk_sys);
         if (wb_ack) begin
            wb_ack  = 1'b0;
            ack_cnt = 0;
         end else if (force_ack) begin
            wb_ack = 1'b1;
         end else if (slave_en && wb_cyc) begin
            if (ack_cnt == 0) begin
               ref_adr = wb_adr;
               ref_dat = wb_dat_o;
               ref_sel = wb_sel;
            end else if (wb_adr !== ref_adr || wb_dat_o !== ref_dat || wb_sel !== ref_sel || !wb_stb || !wb_we) begin
               stab_err++;
            end
            if (ack_cnt == ack_dly) begin
               wb_ack = 1'b1;
               log_adr.push_back(wb_adr);
               log_dat.push_back(wb_dat_o);
               log_sel.push_back(wb_sel);
            end else begin
               ack_cnt++;
            end
         end
      end
   end

   int done_cnt;
   initial begin
      done_cnt = 0;
      forever begin
         @(negedge clk_sys);
         if (done === 1'b1) done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic strobe(input logic [24:0] addr, input logic [15:0] dout);
      @(negedge clk_sys);
      ioctl_addr = addr;
      ioctl_dout = dout;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
   endtask

   task automatic send_hw(input logic [24:0] addr, input logic [15:0] dout, output logic saw_wait);
      strobe(addr, dout);
      saw_wait = ioctl_wait;
      for (int i = 0; i < 100 && ioctl_wait; i++) @(negedge clk_sys);
      chk("wait_release", {31'd0, ioctl_wait}, 32'd0);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic start_dl();
      @(negedge clk_sys);
      dl_active = 1'b1;
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic end_dl(input string name);
      int d0;
      d0 = done_cnt;
      @(negedge clk_sys);
      dl_active = 1'b0;
      repeat (30) @(negedge clk_sys);
      chk({name, "_done_pulse"}, done_cnt - d0, 1);
   endtask

   typedef struct {
      logic [24:0] addr;
      logic [15:0] dout;
      int          n_wr;
      logic [25:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [21:0] words;
   } vec_t;

   vec_t vecs[9];
   int   log_idx;
   int   n_new;
   int   first_ack;
   int   lo_cnt;
   int   d_base;
   int   s_base;
   logic saw_wait;
   logic wait_after;
   logic cyc_after;

   initial begin
      vecs[0] = '{25'h00, 16'h1111, 0, 26'h000000, 32'h00000000, 4'h0, 22'd0};
      vecs[1] = '{25'h02, 16'h2222, 1, 26'h400000, 32'h22221111, 4'hF, 22'd1};
      vecs[2] = '{25'h04, 16'h3333, 0, 26'h000000, 32'h00000000, 4'h0, 22'd1};
      vecs[3] = '{25'h06, 16'h4444, 1, 26'h400004, 32'h44443333, 4'hF, 22'd2};
      vecs[4] = '{25'h0A, 16'h5555, 1, 26'h400008, 32'h55555555, 4'hC, 22'd3};
      vecs[5] = '{25'h0C, 16'h6666, 0, 26'h000000, 32'h00000000, 4'h0, 22'd3};
      vecs[6] = '{25'h10, 16'h7777, 1, 26'h40000C, 32'h66666666, 4'h3, 22'd4};
      vecs[7] = '{25'h16, 16'h8888, 2, 26'h400014, 32'h88888888, 4'hC, 22'd6};
      vecs[8] = '{25'h18, 16'h9999, 0, 26'h000000, 32'h00000000, 4'h0, 22'd6};

      reset      = 1'b1;
      dl_active  = 1'b0;
      ioctl_wr   = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      slave_en   = 1'b1;
      force_ack  = 1'b0;
      ack_dly    = 0;
      log_idx    = 0;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);

      chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
      chk("rst_stb", {31'd0, wb_stb}, 32'd0);
      chk("rst_we", {31'd0, wb_we}, 32'd0);
      chk("rst_sel", {28'd0, wb_sel}, 32'd0);
      chk("rst_adr", {6'd0, wb_adr}, 32'd0);
      chk("rst_dat", wb_dat_o, 32'd0);
      chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_words", {10'd0, words_written}, 32'd0);
`ifdef ROM_DL_CHECKSUM_EN
      chk("rst_csum", checksum, 32'd0);
`endif

      // Table: one download exercising every packing case
      start_dl();
      for (int i = 0; i < 9; i++) begin
         send_hw(vecs[i].addr, vecs[i].dout, saw_wait);
         n_new = log_adr.size() - log_idx;
         chk($sformatf("v%0d_nwr", i), n_new, vecs[i].n_wr);
         chk($sformatf("v%0d_wait", i), {31'd0, saw_wait}, {31'd0, vecs[i].n_wr != 0});
         chk($sformatf("v%0d_words", i), {10'd0, words_written}, {10'd0, vecs[i].words});
         if (vecs[i].n_wr > 0 && n_new > 0) begin
            chk($sformatf("v%0d_adr", i), {6'd0, log_adr[log_adr.size()-1]}, {6'd0, vecs[i].adr});
            chk($sformatf("v%0d_dat", i), log_dat[log_dat.size()-1], vecs[i].dat);
            chk($sformatf("v%0d_sel", i), {28'd0, log_sel[log_sel.size()-1]}, {28'd0, vecs[i].sel});
         end
         if (i == 7 && n_new == 2) begin
            chk("v7_first_adr", {6'd0, log_adr[log_idx]}, 32'h00400010);
            chk("v7_first_dat", log_dat[log_idx], 32'h77777777);
            chk("v7_first_sel", {28'd0, log_sel[log_idx]}, 32'h3);
         end
         log_idx = log_adr.size();
      end
      end_dl("tbl");
      n_new = log_adr.size() - log_idx;
      chk("tbl_flush_nwr", n_new, 1);
      if (n_new > 0) begin
         chk("tbl_flush_adr", {6'd0, log_adr[log_idx]}, 32'h00400018);
         chk("tbl_flush_dat", log_dat[log_idx], 32'h99999999);
         chk("tbl_flush_sel", {28'd0, log_sel[log_idx]}, 32'h3);
      end
      log_idx = log_adr.size();
      chk("tbl_words", {10'd0, words_written}, 32'd7);
`ifdef ROM_DL_CHECKSUM_EN
      chk("tbl_csum", checksum, 32'h4444BBBA);
`endif

      // Odd length: single low half flushed at download end
      start_dl();
      chk("odd_words_clr", {10'd0, words_written}, 32'd0);
      send_hw(25'h08, 16'hABCD, saw_wait);
      chk("odd_nowait", {31'd0, saw_wait}, 32'd0);
      chk("odd_nobus", log_adr.size() - log_idx, 0);
      end_dl("odd");
      n_new = log_adr.size() - log_idx;
      chk("odd_nwr", n_new, 1);
      if (n_new > 0) begin
         chk("odd_adr", {6'd0, log_adr[log_idx]}, 32'h00400008);
         chk("odd_dat", log_dat[log_idx], 32'hABCDABCD);
         chk("odd_sel", {28'd0, log_sel[log_idx]}, 32'h3);
      end
      log_idx = log_adr.size();
      chk("odd_words", {10'd0, words_written}, 32'd1);
`ifdef ROM_DL_CHECKSUM_EN
      chk("odd_csum", checksum, 32'h0000ABCD);
`endif

      // Late ack: bus and ioctl_wait held until ack, released the cycle after
      ack_dly = 5;
      s_base  = stab_err;
      start_dl();
      strobe(25'h02, 16'hBEEF);
      first_ack  = -1;
      lo_cnt     = 0;
      wait_after = 1'b1;
      cyc_after  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sys);
         #1;
         if (first_ack < 0) begin
            if (!ioctl_wait || !wb_cyc) lo_cnt++;
            if (wb_ack) first_ack = i;
         end else if (i == first_ack + 1) begin
            wait_after = ioctl_wait;
            cyc_after  = wb_cyc;
         end
      end
      chk("late_ack_seen", {31'd0, first_ack >= 0}, 32'd1);
      chk("late_wait_held", lo_cnt, 0);
      chk("late_wait_drop", {31'd0, wait_after}, 32'd0);
      chk("late_cyc_drop", {31'd0, cyc_after}, 32'd0);
      chk("late_stable", stab_err - s_base, 0);
      n_new = log_adr.size() - log_idx;
      chk("late_nwr", n_new, 1);
      if (n_new > 0) begin
         chk("late_adr", {6'd0, log_adr[log_idx]}, 32'h00400000);
         chk("late_dat", log_dat[log_idx], 32'hBEEFBEEF);
         chk("late_sel", {28'd0, log_sel[log_idx]}, 32'hC);
      end
      log_idx = log_adr.size();
      ack_dly = 0;
      end_dl("late");

      // Out-of-window write: dropped, sticky overflow, cleared by next download
      start_dl();
      send_hw(25'h400000, 16'h1234, saw_wait);
      chk("ovf_nowait", {31'd0, saw_wait}, 32'd0);
      chk("ovf_nobus", log_adr.size() - log_idx, 0);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      end_dl("ovf");
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);
      chk("ovf_nobus_end", log_adr.size() - log_idx, 0);
      start_dl();
      chk("ovf_clear", {31'd0, overflow}, 32'd0);

      // Reset during a write, then a stray late ack
      slave_en = 1'b0;
      d_base   = done_cnt;
      strobe(25'h02, 16'hCAFE);
      chk("rstw_cyc_pre", {31'd0, wb_cyc}, 32'd1);
      reset     = 1'b1;
      dl_active = 1'b0;
      @(negedge clk_sys);
      chk("rstw_cyc", {31'd0, wb_cyc}, 32'd0);
      chk("rstw_stb", {31'd0, wb_stb}, 32'd0);
      reset = 1'b0;
      @(negedge clk_sys);
      #1 force_ack = 1'b1;
      @(negedge clk_sys);
      #1 force_ack = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("rstw_cyc_post", {31'd0, wb_cyc}, 32'd0);
      chk("rstw_words", {10'd0, words_written}, 32'd0);
      chk("rstw_wait", {31'd0, ioctl_wait}, 32'd0);
      chk("rstw_nodone", done_cnt - d_base, 0);
      slave_en = 1'b1;

`ifdef ROM_DL_CHECKSUM_EN
      // Two full words whose sum wraps to zero
      start_dl();
      send_hw(25'h00, 16'h0001, saw_wait);
      send_hw(25'h02, 16'h0000, saw_wait);
      send_hw(25'h04, 16'hFFFF, saw_wait);
      send_hw(25'h06, 16'hFFFF, saw_wait);
      end_dl("csum");
      chk("csum_words", {10'd0, words_written}, 32'd2);
      chk("csum_wrap", checksum, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
